// File: rtl/ttl_pkg.sv
// Shared definitions for the 74xx sequential logic models.
// The edge typedef is reused by the 74165 and other clocked parts.
package ttl_pkg;

  localparam int TTL595_WIDTH = 8;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } ttl_edge_e;

endpackage

// File: rtl/ttl_595_shift_latch_if.sv
// Pin-level bundle of the 74HC595 model: board-side controls in, latched outputs back.
interface ttl_595_shift_latch_if
  import ttl_pkg::*;
#(
  parameter int WIDTH = TTL595_WIDTH
);

  logic             SER;
  logic             SRCLK;
  logic             RCLK;
  logic             SRCLR_N;
  logic             OE_N;
  logic [WIDTH-1:0] Q;
  logic             Q_OE;
  logic             QH_S;

  modport master (
    output SER, SRCLK, RCLK, SRCLR_N, OE_N,
    input  Q, Q_OE, QH_S
  );

  modport slave (
    input  SER, SRCLK, RCLK, SRCLR_N, OE_N,
    output Q, Q_OE, QH_S
  );

endinterface

// File: rtl/ttl_rise_detect.sv
// Converts a level that is synchronous to clk into a one-cycle rising-edge pulse.
// The history flop resets to 1, so a level held high through reset yields no pulse.
module ttl_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/ttl_595_shift_latch.sv
// Cycle-accurate SN74HC595 model: serial shift register, storage latch, output enable.
// SRCLK and RCLK are level inputs whose rising edges are detected on CLK.
module ttl_595_shift_latch
  import ttl_pkg::*;
#(
  parameter int WIDTH = TTL595_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  ttl_595_shift_latch_if.slave  bus
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] st;
  logic             sr_edge;
  logic             st_edge;

  ttl_rise_detect u_srclk_edge (
    .clk   (CLK),
    .rst   (RST),
    .level (bus.SRCLK),
    .pulse (sr_edge)
  );

  ttl_rise_detect u_rclk_edge (
    .clk   (CLK),
    .rst   (RST),
    .level (bus.RCLK),
    .pulse (st_edge)
  );

  // Clear wins over a coincident shift edge, as on the real part.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr <= '0;
    end else if (!bus.SRCLR_N) begin
      sr <= '0;
    end else if (sr_edge) begin
      sr <= {sr[WIDTH-2:0], bus.SER};
    end
  end

  // Storage samples the pre-update shift register, so tied SRCLK/RCLK lags one stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= '0;
    end else if (st_edge) begin
      st <= sr;
    end
  end

  assign bus.Q    = bus.OE_N ? '0 : st;
  assign bus.Q_OE = ~bus.OE_N;
  assign bus.QH_S = sr[WIDTH-1];

endmodule

// File: tb/tb_ttl_595_shift_latch.sv
// Self-checking bench for the 74HC595 model: vector tables plus hand-written corner sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_ttl_595_shift_latch;

  localparam int W = 8;

  typedef struct {
    logic       ser;
    logic       srclk;
    logic       rclk;
    logic       srclr_n;
    logic       oe_n;
    logic [7:0] exp_q;
    logic       exp_q_oe;
    logic       exp_qhs;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       q_oe;
    logic       qhs;
    string      tag;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  vec_t tbl2[$];
  vec_t tbl4[$];

  ttl_595_shift_latch_if #(.WIDTH(W)) bus ();

  ttl_595_shift_latch #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, want);
    end
  endtask

  // Drive one cycle of pin levels and queue what the outputs must be after the next edge.
  task automatic applyStimulus(input logic ser, input logic srclk, input logic rclk,
                               input logic srclr_n, input logic oe_n, input logic [7:0] eq,
                               input logic eoe, input logic eqh, input string tag);
    exp_t e;
    @(negedge CLK);
    bus.SER     = ser;
    bus.SRCLK   = srclk;
    bus.RCLK    = rclk;
    bus.SRCLR_N = srclr_n;
    bus.OE_N    = oe_n;
    e.q    = eq;
    e.q_oe = eoe;
    e.qhs  = eqh;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic applyVec(input vec_t v, input string tag);
    applyStimulus(v.ser, v.srclk, v.rclk, v.srclr_n, v.oe_n, v.exp_q, v.exp_q_oe, v.exp_qhs, tag);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic vec_t mk(input logic ser, input logic srclk, input logic rclk,
                              input logic srclr_n, input logic oe_n, input logic [7:0] eq,
                              input logic eoe, input logic eqh);
    vec_t v;
    v.ser = ser; v.srclk = srclk; v.rclk = rclk; v.srclr_n = srclr_n; v.oe_n = oe_n;
    v.exp_q = eq; v.exp_q_oe = eoe; v.exp_qhs = eqh;
    return v;
  endfunction

  always @(posedge CLK) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      checkOutput({cur.tag, " Q"}, bus.Q, cur.q);
      checkOutput({cur.tag, " Q_OE"}, {7'b0, bus.Q_OE}, {7'b0, cur.q_oe});
      checkOutput({cur.tag, " QH_S"}, {7'b0, bus.QH_S}, {7'b0, cur.qhs});
    end
  end

  initial begin
    logic [7:0] stream;
    logic [7:0] data;
    logic [7:0] eq;
    logic [7:0] prev_q;
    logic       prev_qh;

    // Serial stream 1,0,1,1,0,0,1,0 (first bit ends in QH) then one store.
    stream = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      tbl2.push_back(mk(stream[7-i], 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
      tbl2.push_back(mk(stream[7-i], 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, i == 7));
    end
    tbl2.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1));
    tbl2.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1));

    // From sr=st=0xFF: clear, shift 0xA5, store, then exercise output enable.
    data = 8'hA5;
    tbl4.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) begin
      tbl4.push_back(mk(data[7-i], 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0));
      tbl4.push_back(mk(data[7-i], 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, i == 7));
    end
    tbl4.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1));
    tbl4.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1));
    tbl4.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1));
    tbl4.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1));
    tbl4.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1));

    bus.SER = 1'b1; bus.SRCLK = 1'b1; bus.RCLK = 1'b1; bus.SRCLR_N = 1'b1; bus.OE_N = 1'b0;
    #2;
    checkOutput("reset Q", bus.Q, 8'h00);
    checkOutput("reset QH_S", {7'b0, bus.QH_S}, 8'h00);
    checkOutput("reset Q_OE", {7'b0, bus.Q_OE}, 8'h01);
    bus.OE_N = 1'b1;
    #1;
    checkOutput("reset Q_OE disabled", {7'b0, bus.Q_OE}, 8'h00);
    bus.OE_N = 1'b0;

    // Levels held high across reset release must not shift or store.
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "hold");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "hold rclk low");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "hold store");

    for (int i = 0; i < tbl2.size(); i++) applyVec(tbl2[i], $sformatf("stream%0d", i));
    drain();

    // Tied SRCLK/RCLK: storage lags the shift register by one stage.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0, "tied clr");
    prev_q  = 8'hB2;
    prev_qh = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      eq = 8'((9'd1 << (k - 1)) - 9'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, prev_q, 1'b1, prev_qh, $sformatf("tied%0d low", k));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, eq, 1'b1, k >= 8, $sformatf("tied%0d", k));
      prev_q  = eq;
      prev_qh = (k >= 8);
    end
    drain();

    for (int i = 0; i < tbl4.size(); i++) applyVec(tbl4[i], $sformatf("oe%0d", i));
    drain();

    // Output enable acts combinationally, before any clock edge.
    @(negedge CLK);
    bus.OE_N = 1'b1;
    #1;
    checkOutput("oe comb Q", bus.Q, 8'h00);
    checkOutput("oe comb Q_OE", {7'b0, bus.Q_OE}, 8'h00);
    bus.OE_N = 1'b0;
    #1;
    checkOutput("oe comb Q back", bus.Q, 8'hA5);
    checkOutput("oe comb Q_OE back", {7'b0, bus.Q_OE}, 8'h01);

    // Clear coincident with both edges, starting from sr=0x3C, st=0xA5.
    data = 8'h3C;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, "pre clr");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(data[7-i], 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, "load3C low");
      applyStimulus(data[7-i], 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, "load3C");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, "clk low");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, "clr+edges");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, "post clr low");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "sr after clr");

    // Four shifts and a store, then an asynchronous reset mid-cycle.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "part low");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, $sformatf("part%0d", k));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "part rclk low");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, "part store");
    drain();
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    checkOutput("async rst Q", bus.Q, 8'h00);
    checkOutput("async rst QH_S", {7'b0, bus.QH_S}, 8'h00);
    checkOutput("async rst Q_OE", {7'b0, bus.Q_OE}, 8'h01);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "post rst hold");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, $sformatf("fresh%0d low", k));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, k == 8, $sformatf("fresh%0d", k));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "fresh rclk low");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, "fresh store");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
